// File: rtl/ct_mmu_utlb_entry_pgs.sv
`default_nettype none
// ============================================================================
// Module   : ct_mmu_utlb_entry_pgs
// Brief    : Single micro-TLB entry (4K/2M/1G pages) with refill poisoning and
//            LRU age. Option macro: MMU_UTLB_ASID_EN (ASID/global qualification).
// Revision : 1.0 - initial release
// ============================================================================
module ct_mmu_utlb_entry_pgs #(
  parameter int NUM_PORTS  = 2,
  parameter int VPN_WIDTH  = 27,
  parameter int PPN_WIDTH  = 28,
  parameter int FLG_WIDTH  = 14,
  parameter int ASID_WIDTH = 16,
  parameter int AGE_WIDTH  = 3
) (
  input  logic                           utlb_entry_clk,
  input  logic                           cpurst_b,
  input  logic [NUM_PORTS*VPN_WIDTH-1:0] utlb_req_vpn,
  input  logic [ASID_WIDTH-1:0]          utlb_req_asid,
  input  logic                           utlb_entry_alloc,
  input  logic [VPN_WIDTH-1:0]           utlb_alloc_vpn,
  input  logic                           utlb_refill_vld,
  input  logic                           utlb_refill_err,
  input  logic [1:0]                     utlb_refill_pgs,
  input  logic [PPN_WIDTH-1:0]           utlb_refill_ppn,
  input  logic [FLG_WIDTH-1:0]           utlb_refill_flg,
  input  logic [ASID_WIDTH-1:0]          utlb_refill_asid,
  input  logic                           utlb_refill_glb,
  input  logic                           utlb_clr,
  input  logic                           utlb_inv_va_req,
  input  logic [VPN_WIDTH-1:0]           utlb_inv_va,
  input  logic                           utlb_inv_asid_req,
  input  logic [ASID_WIDTH-1:0]          utlb_inv_asid,
  input  logic                           utlb_age_tick,
  output logic                           utlb_entry_vld,
  output logic                           utlb_entry_pend,
  output logic [NUM_PORTS-1:0]           utlb_entry_hit,
  output logic [PPN_WIDTH-1:0]           utlb_entry_ppn,
  output logic [FLG_WIDTH-1:0]           utlb_entry_flg,
  output logic [1:0]                     utlb_entry_pgs,
  output logic [AGE_WIDTH-1:0]           utlb_entry_age
);

  localparam logic [VPN_WIDTH-1:0] c_mask_4k  = {VPN_WIDTH{1'b1}};
  localparam logic [VPN_WIDTH-1:0] c_mask_2m  = {{(VPN_WIDTH-9){1'b1}}, 9'b0};
  localparam logic [VPN_WIDTH-1:0] c_mask_1g  = {{(VPN_WIDTH-18){1'b1}}, 18'b0};
  localparam logic [AGE_WIDTH-1:0] c_age_max  = {AGE_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_INVALID = 2'b00,
    ST_PENDING = 2'b01,
    ST_VALID   = 2'b10
  } state_e;

  state_e                r_state;
  logic                  r_poison;
  logic [VPN_WIDTH-1:0]  r_vpn;
  logic [PPN_WIDTH-1:0]  r_ppn;
  logic [FLG_WIDTH-1:0]  r_flg;
  logic [1:0]            r_pgs;
  logic [AGE_WIDTH-1:0]  r_age;

  logic [VPN_WIDTH-1:0]  w_mask;
  logic                  w_asid_ok;
  logic                  w_inv_asid_hit;
  logic                  w_inv_va_valid;
  logic                  w_inv_va_pend;
  logic                  w_refill_pend;
  logic                  w_refill_ok;

  // pgs = 11 is reserved and falls back to a 4K compare
  always_comb begin
    case (r_pgs)
      2'b01:   w_mask = c_mask_2m;
      2'b10:   w_mask = c_mask_1g;
      default: w_mask = c_mask_4k;
    endcase
  end

`ifdef MMU_UTLB_ASID_EN
  logic [ASID_WIDTH-1:0] r_asid;
  logic                  r_glb;

  assign w_asid_ok      = r_glb || (r_asid == utlb_req_asid);
  assign w_inv_asid_hit = utlb_inv_asid_req && (r_state == ST_VALID) &&
                          !r_glb && (r_asid == utlb_inv_asid);
`else
  logic w_unused_asid;

  assign w_asid_ok      = 1'b1;
  assign w_inv_asid_hit = 1'b0;
  assign w_unused_asid  = ^{utlb_req_asid, utlb_refill_asid, utlb_refill_glb,
                            utlb_inv_asid_req, utlb_inv_asid};
`endif

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_hit
    assign utlb_entry_hit[p] = (r_state == ST_VALID) && w_asid_ok &&
        (((utlb_req_vpn[p*VPN_WIDTH +: VPN_WIDTH] ^ r_vpn) & w_mask) == '0);
  end

  // A pending walk has no page size yet, so invalidation poisons on exact VPN
  assign w_inv_va_valid = utlb_inv_va_req && (r_state == ST_VALID) && w_asid_ok &&
                          (((utlb_inv_va ^ r_vpn) & w_mask) == '0);
  assign w_inv_va_pend  = utlb_inv_va_req && (r_state == ST_PENDING) &&
                          (utlb_inv_va == r_vpn);
  assign w_refill_pend  = utlb_refill_vld && (r_state == ST_PENDING);
  assign w_refill_ok    = w_refill_pend && !utlb_refill_err && !r_poison;

  always_ff @(posedge utlb_entry_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_state  <= ST_INVALID;
      r_poison <= 1'b0;
      r_vpn    <= '0;
      r_ppn    <= '0;
      r_flg    <= '0;
      r_pgs    <= 2'b00;
`ifdef MMU_UTLB_ASID_EN
      r_asid   <= '0;
      r_glb    <= 1'b0;
`endif
    end else if (utlb_clr) begin
      r_state  <= ST_INVALID;
      r_poison <= 1'b0;
    end else if (w_inv_va_valid || w_inv_asid_hit) begin
      r_state  <= ST_INVALID;
    end else if (w_inv_va_pend) begin
      // A refill landing in the same cycle is already stale
      r_poison <= 1'b1;
      if (utlb_refill_vld) begin
        r_state <= ST_INVALID;
      end
    end else if (w_refill_pend) begin
      if (utlb_refill_err || r_poison) begin
        r_state <= ST_INVALID;
      end else begin
        r_state <= ST_VALID;
        r_ppn   <= utlb_refill_ppn;
        r_flg   <= utlb_refill_flg;
        r_pgs   <= utlb_refill_pgs;
`ifdef MMU_UTLB_ASID_EN
        r_asid  <= utlb_refill_asid;
        r_glb   <= utlb_refill_glb;
`endif
      end
    end else if (utlb_entry_alloc) begin
      r_state  <= ST_PENDING;
      r_vpn    <= utlb_alloc_vpn;
      r_poison <= 1'b0;
    end
  end

  always_ff @(posedge utlb_entry_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_age <= '0;
    end else if (w_refill_ok || (|utlb_entry_hit)) begin
      r_age <= '0;
    end else if (utlb_age_tick && (r_state == ST_VALID) && (r_age != c_age_max)) begin
      r_age <= r_age + 1'b1;
    end
  end

  assign utlb_entry_vld  = (r_state == ST_VALID);
  assign utlb_entry_pend = (r_state == ST_PENDING);
  assign utlb_entry_ppn  = r_ppn;
  assign utlb_entry_flg  = r_flg;
  assign utlb_entry_pgs  = r_pgs;
  assign utlb_entry_age  = (r_state == ST_VALID) ? r_age : c_age_max;

endmodule
`default_nettype wire

// File: tb/tb_ct_mmu_utlb_entry_pgs.sv
`default_nettype none
// ============================================================================
// Module   : tb_ct_mmu_utlb_entry_pgs
// Brief    : Directed vector table, corner sequences and randomized model check.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ct_mmu_utlb_entry_pgs;

  localparam int NP = 2, VW = 27, PW = 28, FW = 14, AW = 16, GW = 3;
  localparam int AGE_MAX = (1 << GW) - 1;
  localparam int OP_IDLE = 0, OP_ALLOC = 1, OP_RF = 2, OP_CLRRF = 3, OP_INV = 4, OP_TICK = 5;

  logic             clk = 1'b0;
  logic             rst_b = 1'b0;
  logic [NP*VW-1:0] req_vpn;
  logic [AW-1:0]    req_asid;
  logic             alloc;
  logic [VW-1:0]    alloc_vpn;
  logic             rf_vld, rf_err, rf_glb;
  logic [1:0]       rf_pgs;
  logic [PW-1:0]    rf_ppn;
  logic [FW-1:0]    rf_flg;
  logic [AW-1:0]    rf_asid;
  logic             clr, inv_va_req, inv_asid_req, tick;
  logic [VW-1:0]    inv_va;
  logic [AW-1:0]    inv_asid;
  logic             vld, pend;
  logic [NP-1:0]    hit;
  logic [PW-1:0]    ppn;
  logic [FW-1:0]    flg;
  logic [1:0]       pgs;
  logic [GW-1:0]    age;

  int checks = 0;
  int errors = 0;

  ct_mmu_utlb_entry_pgs dut (
    .utlb_entry_clk   (clk),
    .cpurst_b         (rst_b),
    .utlb_req_vpn     (req_vpn),
    .utlb_req_asid    (req_asid),
    .utlb_entry_alloc (alloc),
    .utlb_alloc_vpn   (alloc_vpn),
    .utlb_refill_vld  (rf_vld),
    .utlb_refill_err  (rf_err),
    .utlb_refill_pgs  (rf_pgs),
    .utlb_refill_ppn  (rf_ppn),
    .utlb_refill_flg  (rf_flg),
    .utlb_refill_asid (rf_asid),
    .utlb_refill_glb  (rf_glb),
    .utlb_clr         (clr),
    .utlb_inv_va_req  (inv_va_req),
    .utlb_inv_va      (inv_va),
    .utlb_inv_asid_req(inv_asid_req),
    .utlb_inv_asid    (inv_asid),
    .utlb_age_tick    (tick),
    .utlb_entry_vld   (vld),
    .utlb_entry_pend  (pend),
    .utlb_entry_hit   (hit),
    .utlb_entry_ppn   (ppn),
    .utlb_entry_flg   (flg),
    .utlb_entry_pgs   (pgs),
    .utlb_entry_age   (age)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1);
  end

  typedef struct {
    int          op;
    logic [VW-1:0] a;
    logic [1:0]  pg;
    logic [PW-1:0] pp;
    logic [VW-1:0] rq0, rq1;
    bit          e_vld, e_pend;
    logic [NP-1:0] e_hit;
    int          e_age;
  } vec_t;

  vec_t tbl[$];

  // ---------------- reference model (page arithmetic, not bit masks) -------
  int          m_st;    // 0 invalid, 1 pending, 2 valid
  bit          m_pois;
  logic [VW-1:0] m_vpn;
  logic [PW-1:0] m_ppn;
  logic [FW-1:0] m_flg;
  logic [1:0]  m_pgs;
  int          m_age;
  logic [AW-1:0] m_asid;
  bit          m_glb;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint unsigned pg_units(input logic [1:0] p);
    if (p == 2'b01) return 512;
    if (p == 2'b10) return 262144;
    return 1;
  endfunction

  function automatic bit same_page(input logic [VW-1:0] x, input logic [VW-1:0] y, input logic [1:0] p);
    return (longint'(x) / pg_units(p)) == (longint'(y) / pg_units(p));
  endfunction

  function automatic bit m_asid_ok();
`ifdef MMU_UTLB_ASID_EN
    return m_glb || (m_asid == req_asid);
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [NP-1:0] m_hit();
    logic [NP-1:0] h;
    logic [VW-1:0] v;
    for (int p = 0; p < NP; p++) begin
      v = req_vpn[p*VW +: VW];
      h[p] = (m_st == 2) && m_asid_ok() && same_page(v, m_vpn, m_pgs);
    end
    return h;
  endfunction

  task automatic model_reset();
    m_st = 0; m_pois = 0; m_vpn = '0; m_ppn = '0; m_flg = '0; m_pgs = 2'b00;
    m_age = 0; m_asid = '0; m_glb = 0;
  endtask

  task automatic model_step();
    int  n_st = m_st;
    bit  became_valid = 0;
    bit  any_hit = (m_hit() != '0);
    bit  inv_asid_hit = 0;
`ifdef MMU_UTLB_ASID_EN
    inv_asid_hit = inv_asid_req && (m_st == 2) && !m_glb && (m_asid == inv_asid);
`endif
    if (clr) begin
      n_st = 0; m_pois = 0;
    end else if ((inv_va_req && m_st == 2 && m_asid_ok() && same_page(inv_va, m_vpn, m_pgs)) || inv_asid_hit) begin
      n_st = 0;
    end else if (inv_va_req && m_st == 1 && inv_va == m_vpn) begin
      m_pois = 1;
      if (rf_vld) n_st = 0;
    end else if (rf_vld && m_st == 1) begin
      if (rf_err || m_pois) n_st = 0;
      else begin
        n_st = 2; became_valid = 1;
        m_ppn = rf_ppn; m_flg = rf_flg; m_pgs = rf_pgs; m_asid = rf_asid; m_glb = rf_glb;
      end
    end else if (alloc) begin
      n_st = 1; m_vpn = alloc_vpn; m_pois = 0;
    end
    if (became_valid || any_hit) m_age = 0;
    else if (tick && m_st == 2) m_age = (m_age + 1 > AGE_MAX) ? AGE_MAX : m_age + 1;
    m_st = n_st;
  endtask

  task automatic model_compare();
    chk("rnd_vld",  vld,  (m_st == 2));
    chk("rnd_pend", pend, (m_st == 1));
    chk("rnd_hit",  hit,  m_hit());
    chk("rnd_age",  age,  (m_st == 2) ? m_age : AGE_MAX);
    chk("rnd_ppn",  ppn,  m_ppn);
    chk("rnd_flg",  flg,  m_flg);
    chk("rnd_pgs",  pgs,  m_pgs);
  endtask

  // ---------------- stimulus helpers -------------------------------------
  task automatic drive_idle();
    req_vpn = '0; req_asid = '0; alloc = 0; alloc_vpn = '0;
    rf_vld = 0; rf_err = 0; rf_pgs = 2'b00; rf_ppn = '0; rf_flg = '0; rf_asid = '0; rf_glb = 0;
    clr = 0; inv_va_req = 0; inv_va = '0; inv_asid_req = 0; inv_asid = '0; tick = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input int op, input int a, input int pg, input int pp,
                              input int rq0, input int rq1, input bit ev, input bit ep,
                              input int eh, input int ea);
    vec_t v;
    v.op = op; v.a = VW'(a); v.pg = 2'(pg); v.pp = PW'(pp); v.rq0 = VW'(rq0); v.rq1 = VW'(rq1);
    v.e_vld = ev; v.e_pend = ep; v.e_hit = NP'(eh); v.e_age = ea;
    return v;
  endfunction

  function automatic logic [VW-1:0] rvpn();
    logic [VW-1:0] base, off;
    case ($urandom_range(0, 4))
      0: base = 27'h0001234;
      1: base = 27'h0000200;
      2: base = 27'h0040000;
      3: base = m_vpn;
      default: base = VW'($urandom);
    endcase
    case ($urandom_range(0, 5))
      0: off = 27'h0;
      1: off = 27'h1;
      2: off = 27'h100;
      3: off = 27'h1FF;
      4: off = 27'h200;
      default: off = 27'h3FFFF;
    endcase
    return base ^ off;
  endfunction

  task automatic rand_inputs();
    req_vpn      = {rvpn(), rvpn()};
    req_asid     = AW'($urandom_range(0, 2));
    alloc        = ($urandom_range(0, 5) == 0);
    alloc_vpn    = rvpn();
    rf_vld       = ($urandom_range(0, 3) == 0);
    rf_err       = ($urandom_range(0, 3) == 0);
    rf_pgs       = 2'($urandom_range(0, 3));
    rf_ppn       = PW'($urandom);
    rf_flg       = FW'($urandom);
    rf_asid      = AW'($urandom_range(0, 2));
    rf_glb       = ($urandom_range(0, 3) == 0);
    clr          = ($urandom_range(0, 39) == 0);
    inv_va_req   = ($urandom_range(0, 11) == 0);
    inv_va       = rvpn();
    inv_asid_req = ($urandom_range(0, 14) == 0);
    inv_asid     = AW'($urandom_range(0, 2));
    tick         = ($urandom_range(0, 2) == 0);
  endtask

  initial begin
    drive_idle();

    tbl.push_back(mk(OP_IDLE,  0,        0, 0,       'h1234,  0,       0, 0, 0, 7));
    tbl.push_back(mk(OP_ALLOC, 'h1234,   0, 0,       0,       0,       0, 0, 0, 7));
    tbl.push_back(mk(OP_RF,    0,        0, 'hABCDE, 'h1234,  0,       0, 1, 0, 7));
    tbl.push_back(mk(OP_IDLE,  0,        0, 0,       'h1234,  'h1235,  1, 0, 1, 0));
    tbl.push_back(mk(OP_IDLE,  0,        0, 0,       'h1235,  'h1234,  1, 0, 2, 0));
    tbl.push_back(mk(OP_ALLOC, 'h200,    0, 0,       0,       0,       1, 0, 0, 0));
    tbl.push_back(mk(OP_RF,    0,        1, 'h11,    0,       0,       0, 1, 0, 7));
    tbl.push_back(mk(OP_IDLE,  0,        0, 0,       'h3FF,   'h400,   1, 0, 1, 0));
    tbl.push_back(mk(OP_IDLE,  0,        0, 0,       'h1FF,   'h200,   1, 0, 2, 0));
    tbl.push_back(mk(OP_ALLOC, 'h1234,   0, 0,       0,       0,       1, 0, 0, 0));
    tbl.push_back(mk(OP_INV,   'h1234,   0, 0,       0,       0,       0, 1, 0, 7));
    tbl.push_back(mk(OP_RF,    0,        0, 'h5,     0,       0,       0, 1, 0, 7));
    tbl.push_back(mk(OP_IDLE,  0,        0, 0,       0,       0,       0, 0, 0, 7));
    tbl.push_back(mk(OP_ALLOC, 'h55,     0, 0,       0,       0,       0, 0, 0, 7));
    tbl.push_back(mk(OP_CLRRF, 0,        0, 'h6,     0,       0,       0, 1, 0, 7));
    tbl.push_back(mk(OP_RF,    0,        0, 'h7,     0,       0,       0, 0, 0, 7));
    tbl.push_back(mk(OP_IDLE,  0,        0, 0,       0,       0,       0, 0, 0, 7));
    tbl.push_back(mk(OP_ALLOC, 'h77,     0, 0,       0,       0,       0, 0, 0, 7));
    tbl.push_back(mk(OP_RF,    0,        0, 'h22,    0,       0,       0, 1, 0, 7));
    for (int i = 0; i < 9; i++)
      tbl.push_back(mk(OP_TICK, 0, 0, 0, 0, 0, 1, 0, 0, (i > 7) ? 7 : i));
    tbl.push_back(mk(OP_TICK,  0,        0, 0,       'h77,    0,       1, 0, 1, 7));
    tbl.push_back(mk(OP_IDLE,  0,        0, 0,       0,       0,       1, 0, 0, 0));
    tbl.push_back(mk(OP_ALLOC, 'h40000,  0, 0,       0,       0,       1, 0, 0, 0));
    tbl.push_back(mk(OP_RF,    0,        2, 'h33,    0,       0,       0, 1, 0, 7));
    tbl.push_back(mk(OP_IDLE,  0,        0, 0,       'h7FFFF, 'h3FFFF, 1, 0, 1, 0));
    tbl.push_back(mk(OP_ALLOC, 'h900,    0, 0,       0,       0,       1, 0, 0, 0));
    tbl.push_back(mk(OP_RF,    0,        3, 'h44,    0,       0,       0, 1, 0, 7));
    tbl.push_back(mk(OP_IDLE,  0,        0, 0,       'h900,   'h901,   1, 0, 1, 0));
    tbl.push_back(mk(OP_INV,   'h901,    0, 0,       'h900,   0,       1, 0, 1, 0));
    tbl.push_back(mk(OP_INV,   'h900,    0, 0,       0,       0,       1, 0, 0, 0));
    tbl.push_back(mk(OP_IDLE,  0,        0, 0,       0,       0,       0, 0, 0, 7));

    repeat (3) @(posedge clk);
    #1;
    rst_b = 1'b1;
    @(negedge clk);
    chk("reset_ppn", ppn, 0);
    chk("reset_flg", flg, 0);
    chk("reset_pgs", pgs, 0);
    chk("reset_hit", hit, 0);

    foreach (tbl[i]) begin
      step();
      drive_idle();
      case (tbl[i].op)
        OP_ALLOC: begin alloc = 1; alloc_vpn = tbl[i].a; end
        OP_RF:    begin rf_vld = 1; rf_pgs = tbl[i].pg; rf_ppn = tbl[i].pp; end
        OP_CLRRF: begin clr = 1; rf_vld = 1; rf_ppn = tbl[i].pp; end
        OP_INV:   begin inv_va_req = 1; inv_va = tbl[i].a; end
        OP_TICK:  tick = 1;
        default:  ;
      endcase
      req_vpn = {tbl[i].rq1, tbl[i].rq0};
      @(negedge clk);
      chk($sformatf("vec%0d_vld", i),  vld,  tbl[i].e_vld);
      chk($sformatf("vec%0d_pend", i), pend, tbl[i].e_pend);
      chk($sformatf("vec%0d_hit", i),  hit,  tbl[i].e_hit);
      chk($sformatf("vec%0d_age", i),  age,  tbl[i].e_age);
    end

    // stored fields and refill ignored while VALID
    step(); drive_idle(); alloc = 1; alloc_vpn = 27'h123;
    step(); drive_idle(); rf_vld = 1; rf_pgs = 2'b01; rf_ppn = 28'hABCDE; rf_flg = 14'h1555;
    step(); drive_idle();
    @(negedge clk);
    chk("store_ppn", ppn, 28'hABCDE);
    chk("store_flg", flg, 14'h1555);
    chk("store_pgs", pgs, 2'b01);
    step(); rf_vld = 1; rf_pgs = 2'b00; rf_ppn = 28'h1;
    step(); drive_idle();
    @(negedge clk);
    chk("valid_refill_ignored_ppn", ppn, 28'hABCDE);
    chk("valid_refill_ignored_vld", vld, 1);

    // asynchronous reset while PENDING, later refill ignored
    step(); alloc = 1; alloc_vpn = 27'h321;
    step(); drive_idle();
    @(negedge clk);
    chk("pre_reset_pend", pend, 1);
    #1 rst_b = 1'b0;
    #1;
    chk("async_reset_pend", pend, 0);
    chk("async_reset_age", age, AGE_MAX);
    chk("async_reset_ppn", ppn, 0);
    step(); rst_b = 1'b1; rf_vld = 1; rf_ppn = 28'h9;
    step(); drive_idle();
    @(negedge clk);
    chk("post_reset_refill_vld", vld, 0);
    chk("post_reset_refill_pend", pend, 0);

`ifdef MMU_UTLB_ASID_EN
    step(); alloc = 1; alloc_vpn = 27'h500;
    step(); drive_idle(); rf_vld = 1; rf_asid = 16'd5; rf_glb = 0;
    step(); drive_idle(); req_vpn = {27'h0, 27'h500}; req_asid = 16'd6;
    @(negedge clk);
    chk("asid_mismatch_hit", hit, 2'b00);
    req_asid = 16'd5;
    #1;
    chk("asid_match_hit", hit, 2'b01);
    step(); drive_idle(); inv_asid_req = 1; inv_asid = 16'd5;
    step(); drive_idle();
    @(negedge clk);
    chk("inv_asid_vld", vld, 0);
`endif

    // randomized run against the model
    step(); drive_idle(); rst_b = 1'b0;
    step(); rst_b = 1'b1;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      rand_inputs();
      @(negedge clk);
      model_compare();
      model_step();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
